// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: word-addressed RAM with WAIT_CYCLES wait states.
// Optional `DMEM_ERR_EN adds a mem_err pulse that flags out-of-range accesses.
module dmem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       MemAcc_addr,
    input  logic [DATA_W-1:0] MemWrite_data,
    output logic [DATA_W-1:0] MemRead_data,
    output logic              mem_stall,
`ifdef DMEM_ERR_EN
    output logic              mem_ack,
    output logic              mem_err
`else
    output logic              mem_ack
`endif
);

    localparam int         DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic                cap_rd;
    logic                cap_wr;
    logic                cap_in_range;
    logic [ADDR_W-1:0]   cap_idx;
    logic [DATA_W-1:0]   cap_data;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                req;
    logic                in_range;
    logic [ADDR_W-1:0]   idx;
    logic                unused_addr_bits;

    assign req              = MemRead | MemWrite;
    assign idx              = MemAcc_addr[ADDR_W+1:2];
    assign in_range         = (MemAcc_addr[31:ADDR_W+2] == '0);
    assign unused_addr_bits = ^MemAcc_addr[1:0];

    // With zero wait states the commit happens on the accepting edge, so the
    // live request is used; otherwise the values captured in IDLE are used.
    logic                use_live;
    logic                enter_done;
    logic                do_rd;
    logic                do_wr;
    logic                do_in_range;
    logic [ADDR_W-1:0]   do_idx;
    logic [DATA_W-1:0]   do_data;
    logic                ram_we;
    logic [DATA_W-1:0]   ram_rdata;

    assign use_live    = (state == ST_IDLE);
    assign do_rd       = use_live ? MemRead       : cap_rd;
    assign do_wr       = use_live ? MemWrite      : cap_wr;
    assign do_in_range = use_live ? in_range      : cap_in_range;
    assign do_idx      = use_live ? idx           : cap_idx;
    assign do_data     = use_live ? MemWrite_data : cap_data;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        enter_done = 1'b0;
        if (state == ST_IDLE) begin
            enter_done = req && (WAIT_CYCLES == 0);
        end else if (state == ST_WAIT) begin
            enter_done = (cnt == 4'd0);
        end
    end

    // Gating with rst keeps an access aborted by reset from reaching the RAM.
    assign ram_we    = rst & enter_done & do_wr & do_in_range;
    assign ram_rdata = mem[do_idx];

    // NOTE: the RAM array has no reset; contents survive rst and it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[do_idx] <= do_data;
        end
    end

`ifdef DMEM_ERR_EN
    logic err_q;
    assign mem_err = err_q;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so a read-while-write
    // samples the pre-write RAM word on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            cnt          <= 4'd0;
            cap_rd       <= 1'b0;
            cap_wr       <= 1'b0;
            cap_in_range <= 1'b0;
            cap_idx      <= '0;
            cap_data     <= '0;
            MemRead_data <= '0;
            mem_ack      <= 1'b0;
`ifdef DMEM_ERR_EN
            err_q        <= 1'b0;
`endif
        end else begin
            mem_ack <= enter_done;
`ifdef DMEM_ERR_EN
            err_q   <= enter_done & ~do_in_range;
`endif
            if (enter_done && do_rd) begin
                MemRead_data <= do_in_range ? ram_rdata : '0;
            end

            case (state)
                ST_IDLE: begin
                    if (req) begin
                        cap_rd       <= MemRead;
                        cap_wr       <= MemWrite;
                        cap_in_range <= in_range;
                        cap_idx      <= idx;
                        cap_data     <= MemWrite_data;
                        if (WAIT_CYCLES == 0) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign mem_stall = rst & (((state == ST_IDLE) & req) | (state == ST_WAIT));

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with 2 wait states, one with zero wait states.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rd_a, wr_a, stall_a, ack_a, err_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic        rd_z, wr_z, stall_z, ack_z, err_z;
    logic [31:0] addr_z, wdata_z, rdata_z;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DATA_W(32), .ADDR_W(10), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .MemRead(rd_a), .MemWrite(wr_a), .MemAcc_addr(addr_a),
        .MemWrite_data(wdata_a), .MemRead_data(rdata_a), .mem_stall(stall_a),
`ifdef DMEM_ERR_EN
        .mem_ack(ack_a), .mem_err(err_a)
`else
        .mem_ack(ack_a)
`endif
    );

    dmem_responder #(.DATA_W(32), .ADDR_W(10), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .rst(rst), .MemRead(rd_z), .MemWrite(wr_z), .MemAcc_addr(addr_z),
        .MemWrite_data(wdata_z), .MemRead_data(rdata_z), .mem_stall(stall_z),
`ifdef DMEM_ERR_EN
        .mem_ack(ack_z), .mem_err(err_z)
`else
        .mem_ack(ack_z)
`endif
    );

`ifndef DMEM_ERR_EN
    assign err_a = 1'b0;
    assign err_z = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit z, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data);
        if (z) begin
            rd_z = rd; wr_z = wr; addr_z = addr; wdata_z = data;
        end else begin
            rd_a = rd; wr_a = wr; addr_a = addr; wdata_a = data;
        end
    endtask

    // One access: request held until mem_ack is seen. corrupt changes addr/data
    // one cycle after issue to show the captured values are the ones used.
    task automatic access(input bit z, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] data, input bit corrupt,
                          output logic [31:0] rdata, output int lat, output int stalls,
                          output logic ack_stall, output logic err, output int ack_cyc);
        @(negedge clk);
        drive(z, rd, wr, addr, data);
        lat    = 0;
        stalls = 0;
        #1;
        while (!(z ? ack_z : ack_a) && lat < 40) begin
            if (z ? stall_z : stall_a) stalls++;
            @(negedge clk);
            lat++;
            if (corrupt && lat == 1) drive(z, rd, wr, addr ^ 32'h4, ~data);
            #1;
        end
        rdata     = z ? rdata_z : rdata_a;
        ack_stall = z ? stall_z : stall_a;
        err       = z ? err_z : err_a;
        ack_cyc   = cyc;
        drive(z, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    logic [31:0] rv;
    logic        ack_st, err;
    int          lat, st, t_ack, t_prev;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with requests held: stall must stay low.
        rst = 1'b0;
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
        drive(1, 1'b1, 1'b1, 32'h4, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall_a", stall_a, 0);
        check("rst_ack_a", ack_a, 0);
        check("rst_rdata_a", rdata_a, 0);
        check("rst_stall_z", stall_z, 0);
`ifdef DMEM_ERR_EN
        check("rst_err_a", err_a, 0);
`endif
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;

        // Write then read with two wait states.
        access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 0, rv, lat, st, ack_st, err, t_ack);
        check("wr_latency", lat, 3);
        check("wr_stall_cycles", st, 3);
        check("wr_stall_in_done", ack_st, 0);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, 0, rv, lat, st, ack_st, err, t_ack);
        check("rd_data_10", rv, 32'hDEADBEEF);
        check("rd_latency", lat, 3);
        check("rd_stall_cycles", st, 3);
        t_prev = t_ack;
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, 0, rv, lat, st, ack_st, err, t_ack);
        check("ack_spacing", t_ack - t_prev, 4);

        // Zero wait states.
        access(1, 1'b0, 1'b1, 32'h4, 32'h12345678, 0, rv, lat, st, ack_st, err, t_ack);
        check("z_wr_latency", lat, 1);
        check("z_wr_stall_cycles", st, 1);
        access(1, 1'b1, 1'b0, 32'h4, 32'h0, 0, rv, lat, st, ack_st, err, t_ack);
        check("z_rd_data", rv, 32'h12345678);
        check("z_rd_latency", lat, 1);

        // Byte offset bits ignored.
        access(0, 1'b0, 1'b1, 32'h22, 32'hA5A5A5A5, 0, rv, lat, st, ack_st, err, t_ack);
        access(0, 1'b1, 1'b0, 32'h20, 32'h0, 0, rv, lat, st, ack_st, err, t_ack);
        check("byte_offset_data", rv, 32'hA5A5A5A5);

        // A write does not disturb the last read value.
        access(0, 1'b0, 1'b1, 32'h0, 32'h00000077, 0, rv, lat, st, ack_st, err, t_ack);
        check("rdata_hold", rv, 32'hA5A5A5A5);

        // Out of range.
        access(0, 1'b0, 1'b1, 32'h1000, 32'h1, 0, rv, lat, st, ack_st, err, t_ack);
        check("oor_wr_latency", lat, 3);
`ifdef DMEM_ERR_EN
        check("oor_wr_err", err, 1);
`endif
        access(0, 1'b1, 1'b0, 32'h1000, 32'h0, 0, rv, lat, st, ack_st, err, t_ack);
        check("oor_rd_data", rv, 32'h0);
`ifdef DMEM_ERR_EN
        check("oor_rd_err", err, 1);
`endif
        access(0, 1'b1, 1'b0, 32'h0, 32'h0, 0, rv, lat, st, ack_st, err, t_ack);
        check("word0_unchanged", rv, 32'h00000077);
`ifdef DMEM_ERR_EN
        check("inrange_err", err, 0);
`endif

        // Simultaneous read+write returns the pre-write word.
        access(0, 1'b0, 1'b1, 32'hC, 32'h11, 0, rv, lat, st, ack_st, err, t_ack);
        access(0, 1'b1, 1'b1, 32'hC, 32'h22, 0, rv, lat, st, ack_st, err, t_ack);
        check("rdwr_old_data", rv, 32'h11);
        access(0, 1'b1, 1'b0, 32'hC, 32'h0, 0, rv, lat, st, ack_st, err, t_ack);
        check("rdwr_new_data", rv, 32'h22);

        // Inputs changed during WAIT are ignored.
        access(0, 1'b0, 1'b1, 32'h34, 32'h0, 0, rv, lat, st, ack_st, err, t_ack);
        access(0, 1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 1, rv, lat, st, ack_st, err, t_ack);
        check("captured_lat", lat, 3);
        access(0, 1'b1, 1'b0, 32'h30, 32'h0, 0, rv, lat, st, ack_st, err, t_ack);
        check("captured_data", rv, 32'hCAFEF00D);
        access(0, 1'b1, 1'b0, 32'h34, 32'h0, 0, rv, lat, st, ack_st, err, t_ack);
        check("corrupt_not_written", rv, 32'h0);

        // Reset during WAIT aborts the write.
        access(0, 1'b0, 1'b1, 32'h8, 32'h99, 0, rv, lat, st, ack_st, err, t_ack);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 32'h8, 32'h55);
        @(negedge clk);
        #1;
        check("midop_stall_wait", stall_a, 1);
        rst = 1'b0;
        #1;
        check("midop_rst_stall", stall_a, 0);
        check("midop_rst_ack", ack_a, 0);
        check("midop_rst_rdata", rdata_a, 0);
        @(negedge clk);
        #1;
        check("midop_rst_stall2", stall_a, 0);
        check("midop_rst_ack2", ack_a, 0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        access(0, 1'b1, 1'b0, 32'h8, 32'h0, 0, rv, lat, st, ack_st, err, t_ack);
        check("midop_old_data", rv, 32'h99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
